// File: rtl/llsc_monitor.sv
// llsc_monitor: multi-channel LL/SC reservation monitor; define LLSC_TIMEOUT_EN to make reservations expire after TIMEOUT cycles
module llsc_monitor #(
  parameter int BITS = 32,
  parameter int CHANNELS = 2,
  parameter int GRANULE_LSB = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      req_valid,
  input  logic [2*CHANNELS-1:0]    req_type,
  input  logic [BITS*CHANNELS-1:0] req_addr,
  output logic [CHANNELS-1:0]      sc_pass,
  output logic [CHANNELS-1:0]      store_en,
  output logic [CHANNELS-1:0]      sc_done,
  output logic [CHANNELS-1:0]      sc_result,
  output logic [CHANNELS-1:0]      rsv_valid,
  output logic [BITS*CHANNELS-1:0] rsv_addr
);
  if (CHANNELS < 1 || CHANNELS > 8 || TIMEOUT < 0 || TIMEOUT >= (1 << CNT_BITS)) begin : g_param_check
    $error("llsc_monitor: CHANNELS must be 1..8 and TIMEOUT below 2**CNT_BITS");
  end
  logic [CHANNELS-1:0] is_ll, is_sc, is_st, is_clr;
  logic [CHANNELS-1:0] rsv_valid_q, rsv_valid_d, sc_done_q, sc_done_d, sc_result_q, sc_result_d;
  logic [BITS-1:0] addr [CHANNELS];
  logic [BITS-1:0] rsv_addr_q [CHANNELS];
  logic [BITS-1:0] rsv_addr_d [CHANNELS];
`ifdef LLSC_TIMEOUT_EN
  logic [CNT_BITS-1:0] age_q [CHANNELS];
  logic [CNT_BITS-1:0] age_d [CHANNELS];
`endif
  function automatic logic same(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    return ((a ^ b) >> GRANULE_LSB) == '0;
  endfunction
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      addr[i] = req_addr[BITS*i +: BITS];
      is_ll[i] = !rst && req_valid[i] && req_type[2*i +: 2] == 2'b00;
      is_sc[i] = !rst && req_valid[i] && req_type[2*i +: 2] == 2'b01;
      is_st[i] = !rst && req_valid[i] && req_type[2*i +: 2] == 2'b10;
      is_clr[i] = !rst && req_valid[i] && req_type[2*i +: 2] == 2'b11;
    end
  end
  always_comb begin
    sc_pass = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sc_pass[i] = is_sc[i] && rsv_valid_q[i] && same(rsv_addr_q[i], addr[i]);
      for (int j = 0; j < CHANNELS; j++)
        if (j != i && (is_st[j] || (j < i && sc_pass[j])) && same(addr[j], addr[i])) sc_pass[i] = 1'b0;
    end
    store_en = is_st | sc_pass;
  end
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      rsv_addr_d[k] = rsv_addr_q[k];
      rsv_valid_d[k] = rsv_valid_q[k] && !is_sc[k] && !is_clr[k];
      for (int j = 0; j < CHANNELS; j++)
        if (j != k && store_en[j] && same(addr[j], rsv_addr_q[k])) rsv_valid_d[k] = 1'b0;
`ifdef LLSC_TIMEOUT_EN
      age_d[k] = (rsv_valid_q[k] && age_q[k] != '1) ? age_q[k] + CNT_BITS'(1) : age_q[k];
      if (rsv_valid_q[k] && age_q[k] == CNT_BITS'(TIMEOUT)) rsv_valid_d[k] = 1'b0;
      if (is_ll[k]) age_d[k] = '0;
`endif
      if (is_ll[k]) begin
        rsv_valid_d[k] = 1'b1;
        rsv_addr_d[k] = (addr[k] >> GRANULE_LSB) << GRANULE_LSB;
      end
    end
    sc_done_d = is_sc;
    sc_result_d = sc_pass | (sc_result_q & ~is_sc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rsv_valid_q <= '0;
      sc_done_q <= '0;
      sc_result_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        rsv_addr_q[k] <= '0;
`ifdef LLSC_TIMEOUT_EN
        age_q[k] <= '0;
`endif
      end
    end else begin
      rsv_valid_q <= rsv_valid_d;
      sc_done_q <= sc_done_d;
      sc_result_q <= sc_result_d;
      for (int k = 0; k < CHANNELS; k++) begin
        rsv_addr_q[k] <= rsv_addr_d[k];
`ifdef LLSC_TIMEOUT_EN
        age_q[k] <= age_d[k];
`endif
      end
    end
  end
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) rsv_addr[BITS*k +: BITS] = rsv_addr_q[k];
    rsv_valid = rsv_valid_q;
    sc_done = sc_done_q;
    sc_result = sc_result_q;
  end
endmodule

// File: doc/llsc_monitor.md
# llsc_monitor

Multi-channel load-link / store-conditional reservation monitor. It generalises the single link register in the CPU top to CHANNELS independent requesters (harts or pipeline ports), each with its own reservation. Coherent invalidation is by granule, same-cycle conflicts are arbitrated, and reservations can optionally expire. It sits beside the data memory in the MEM stage: it gates memory write enables and supplies the atomic SC result for write-back.

## Interface
- BITS, 32, address width
- CHANNELS, 2, number of requesters (1..8)
- GRANULE_LSB, 2, low address bits ignored for matching (reservation granule = 2^GRANULE_LSB bytes)
- TIMEOUT, 255, reservation lifetime in cycles (used only with LLSC_TIMEOUT_EN)
- CNT_BITS, 8, age counter width; must satisfy TIMEOUT < 2^CNT_BITS
- clk  input  1  single clock, all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  CHANNELS  per-channel request strobe
- req_type  input  2*CHANNELS  per-channel type, channel i at [2i+1:2i]: 00 LL, 01 SC, 10 ST (plain store), 11 CLR
- req_addr  input  BITS*CHANNELS  per-channel byte address, channel i at [BITS*i+BITS-1:BITS*i]
- sc_pass  output  CHANNELS  combinational: this cycle's SC succeeds
- store_en  output  CHANNELS  combinational: memory write permitted (ST, or SC with sc_pass)
- sc_done  output  CHANNELS  registered one-cycle pulse, the cycle after an SC
- sc_result  output  CHANNELS  registered SC outcome (1 pass, 0 fail), valid with sc_done, holds otherwise
- rsv_valid  output  CHANNELS  registered reservation valid
- rsv_addr  output  BITS*CHANNELS  registered reservation address, low GRANULE_LSB bits forced to 0

## Operation
- Granule match: addresses equal when bits [BITS-1:GRANULE_LSB] are equal.
- LL on channel i: rsv_addr[i] <= granule-aligned req_addr; rsv_valid[i] <= 1; age[i] <= 0. A new LL replaces any older reservation.
- SC on channel i: sc_pass[i] = 1 only when all of these hold:
  - rsv_valid[i] is set and the granule matches;
  - no channel j != i issues ST to the same granule this cycle;
  - no channel j < i has sc_pass[j] = 1 for the same granule (lowest index wins).
- After an SC, rsv_valid[i] <= 0 whether it passed or failed.
- ST on channel i: store_en[i] = 1 always; no effect on channel i's own reservation.
- CLR on channel i: rsv_valid[i] <= 0 (exception or context switch); no memory effect.
- Invalidation: every other channel k whose reservation granule matches is cleared (rsv_valid[k] <= 0) by:
  - any store_en[i] from channel i (ST or passing SC);
  - any channel's CLR does not invalidate other channels.
- Same-cycle ordering: stores and SCs are ordered before LLs. An LL from channel k in the same cycle as a matching write from channel j leaves channel k's reservation valid.
- store_en/sc_pass are 0 for channels with req_valid = 0; SC fail gives store_en = 0.

## Timing
- sc_pass/store_en: zero-cycle combinational from req_* and registered state.
- Reservation updates: visible one cycle after the request edge.
- sc_done/sc_result: one cycle after SC.
- Back-to-back LL then SC in consecutive cycles is legal and passes.
- On reset, all outputs and internal state are 0: rsv_valid, rsv_addr, age, sc_done, sc_result. Combinational outputs are 0 while req_valid = 0.
- rst asserted mid-operation: all reservations drop at that edge. Requests presented in a reset cycle are ignored; no registered effect, no sc_done.

## Configuration
- LLSC_TIMEOUT_EN defined:
  - age[i] increments each cycle while rsv_valid[i] = 1 and no LL is issued on channel i.
  - At the edge where age[i] == TIMEOUT, rsv_valid[i] <= 0.
  - An SC in the cycle where age == TIMEOUT is still evaluated against the valid reservation and can pass.
  - age saturates; it never wraps.
- LLSC_TIMEOUT_EN undefined: no age counters; reservations persist until SC, CLR, invalidation or reset; TIMEOUT and CNT_BITS are ignored.

## Test plan
- Ch0 LL 0x100, next cycle SC 0x100 -> sc_pass[0]=1, store_en[0]=1; next cycle sc_done[0]=1, sc_result[0]=1, rsv_valid[0]=0.
- Ch0 LL 0x100, ch1 ST 0x102 (same granule, GRANULE_LSB=2), then ch0 SC 0x100 -> sc_pass[0]=0, store_en[0]=0, sc_result[0]=0.
- Ch0 and ch1 both LL 0x200, then both SC 0x200 in the same cycle -> sc_pass=2'b01; ch1 reservation cleared; sc_result=2'b01.
- Ch0 LL 0x300 same cycle as ch1 ST 0x300 -> rsv_valid[0]=1 after the edge; following SC on ch0 passes.
- LLSC_TIMEOUT_EN, TIMEOUT=4: LL, then SC 4 cycles later -> pass. LL, then SC 6 cycles later -> fail, with rsv_valid dropping 5 cycles after the LL.
- Ch0 LL 0x400, rst=1 for one cycle, then SC 0x400 -> all outputs 0 during reset; SC fails.
